// File: rtl/scaler_pkg.sv
// scaler_pkg: shared defaults and FIFO word layout for the scaler output stage.
// Word layout is {pixel, done, tuser, tlast} with the flags packed in the low bits.
package scaler_pkg;
  localparam int PIXEL_BITWIDTH_DEF = 8;
  localparam int WIDTH_BITWIDTH_DEF = 12;
  localparam int LAST_BIT = 0;
  localparam int USER_BIT = 1;
  localparam int DONE_BIT = 2;
  localparam int PIX_LSB  = 3;
endpackage

// File: rtl/scaler_sync_fifo.sv
// scaler_sync_fifo: synchronous FIFO with a registered output word; count includes it.
// i_mark sets the done flag on the most recently written word when no write is in flight.
module scaler_sync_fifo
  import scaler_pkg::*;
#(
  parameter int DW    = 11,
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          core_clk,
  input  logic          core_rst,
  input  logic          i_wr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_mark,
  input  logic          i_rd,
  output logic [DW-1:0] o_rdata,
  output logic          o_valid,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_mem_empty
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_mcnt;
  logic          r_ov;
  logic [DW-1:0] r_out;
  logic [DW-1:0] w_head;
  logic          w_load, w_pop, w_byp, w_push;
  assign w_load      = !r_ov || i_rd;
  assign w_pop       = w_load && r_mcnt != '0;
  assign w_byp       = w_load && r_mcnt == '0 && i_wr;
  assign w_push      = i_wr && !w_byp;
  assign o_count     = r_mcnt + CW'(r_ov);
  assign o_full      = o_count == CW'(DEPTH);
  assign o_empty     = o_count == '0;
  assign o_mem_empty = r_mcnt == '0;
  assign o_valid     = r_ov;
  assign o_rdata     = r_out;
  // a mark racing the pop of the last stored word must follow it into the output register
  always_comb begin
    w_head = r_mem[r_rptr];
    if (i_mark && r_mcnt == CW'(1)) w_head[DONE_BIT] = 1'b1;
  end
  always_ff @(posedge core_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
    if (i_mark && r_mcnt != '0) r_mem[r_wptr - 1'b1][DONE_BIT] <= 1'b1;
  end
  always_ff @(posedge core_clk) begin
    if (!core_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_mcnt <= '0;
      r_ov   <= 1'b0;
      r_out  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_mcnt <= r_mcnt + CW'(w_push) - CW'(w_pop);
      if (w_load) begin
        r_ov <= w_pop || w_byp;
        if (w_pop) r_out <= w_head;
        else if (w_byp) r_out <= i_wdata;
      end else if (i_mark && r_mcnt == '0) begin
        r_out[DONE_BIT] <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/scaler_out_packer.sv
// scaler_out_packer: frames bicubic core pixels into AXI4-Stream video with SOF/EOL flags.
// Define SCALER_OUT_STAT_EN to add frame/line statistics counters.
module scaler_out_packer
  import scaler_pkg::*;
#(
  parameter int PIXEL_BITWIDTH = PIXEL_BITWIDTH_DEF,
  parameter int FIFO_DEPTH     = 32,
  parameter int PIPE_LATENCY   = 10,
  parameter int WIDTH_BITWIDTH = WIDTH_BITWIDTH_DEF
) (
  input  logic                      core_clk,
  input  logic                      core_rst,
  input  logic [WIDTH_BITWIDTH-1:0] cfg_dst_width,
  input  logic                      s_axis_core_valid,
  input  logic [PIXEL_BITWIDTH-1:0] s_axis_core_pixel,
  input  logic                      s_axis_core_done,
  output logic                      s_axis_core_ready,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [PIXEL_BITWIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tuser,
  output logic                      m_axis_tlast,
  output logic                      frame_done,
  output logic                      err_overflow,
`ifdef SCALER_OUT_STAT_EN
  output logic                      err_short_line,
  output logic [31:0]               stat_frame_cnt,
  output logic [WIDTH_BITWIDTH-1:0] stat_line_cnt
`else
  output logic                      err_short_line
`endif
);
  localparam int DW = PIXEL_BITWIDTH + PIX_LSB;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int WB = WIDTH_BITWIDTH;
  logic [WB-1:0] r_col, r_w;
  logic          r_sof_pend, r_frame_done, r_err_ovf, r_err_short;
  logic [WB-1:0] w_w, w_col_adv;
  logic [DW-1:0] w_wdata, w_rdata;
  logic [CW-1:0] w_count;
  logic          w_sof, w_last, w_wr, w_rd, w_mark, w_ov, w_full, w_empty, w_mem_empty;
  assign w_sof     = s_axis_core_valid && r_col == '0 && r_sof_pend;
  assign w_w       = w_sof ? ((cfg_dst_width == '0) ? WB'(1) : cfg_dst_width) : r_w;
  assign w_last    = r_col == w_w - 1'b1;
  assign w_col_adv = !s_axis_core_valid ? r_col : (w_last ? '0 : r_col + 1'b1);
  assign w_wr      = s_axis_core_valid && !w_full;
  assign w_mark    = s_axis_core_done && !w_wr;
  assign w_wdata   = {s_axis_core_pixel, s_axis_core_done, w_sof, w_last};
  assign w_rd      = w_ov && m_axis_tready;
  scaler_sync_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .core_clk    (core_clk),
    .core_rst    (core_rst),
    .i_wr        (w_wr),
    .i_wdata     (w_wdata),
    .i_mark      (w_mark),
    .i_rd        (w_rd),
    .o_rdata     (w_rdata),
    .o_valid     (w_ov),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_mem_empty (w_mem_empty)
  );
  assign m_axis_tvalid     = w_ov;
  assign m_axis_tdata      = w_rdata[PIX_LSB +: PIXEL_BITWIDTH];
  assign m_axis_tuser      = w_rdata[USER_BIT];
  assign m_axis_tlast      = w_rdata[LAST_BIT];
  assign s_axis_core_ready = (CW'(FIFO_DEPTH) - w_count) > CW'(PIPE_LATENCY);
  assign frame_done        = r_frame_done;
  assign err_overflow      = r_err_ovf;
  assign err_short_line    = r_err_short;
  always_ff @(posedge core_clk) begin
    if (!core_rst) begin
      r_col        <= '0;
      r_w          <= WB'(1);
      r_sof_pend   <= 1'b1;
      r_frame_done <= 1'b0;
      r_err_ovf    <= 1'b0;
      r_err_short  <= 1'b0;
    end else begin
      if (w_sof) r_w <= w_w;
      r_col        <= s_axis_core_done ? '0 : w_col_adv;
      r_sof_pend   <= s_axis_core_done || (r_sof_pend && !w_sof);
      // done is carried by the word it lands on, or fires at once if nothing is left to carry it
      r_frame_done <= (w_rd && (w_rdata[DONE_BIT] || (w_mark && w_mem_empty))) || (w_mark && w_empty);
      r_err_ovf    <= r_err_ovf || (s_axis_core_valid && w_full);
      r_err_short  <= r_err_short || (s_axis_core_done && w_col_adv != '0);
    end
  end
`ifdef SCALER_OUT_STAT_EN
  logic [31:0]   r_frame_cnt;
  logic [WB-1:0] r_line_cnt;
  assign stat_frame_cnt = r_frame_cnt;
  assign stat_line_cnt  = r_line_cnt;
  always_ff @(posedge core_clk) begin
    if (!core_rst) begin
      r_frame_cnt <= '0;
      r_line_cnt  <= '0;
    end else begin
      r_frame_cnt <= r_frame_cnt + 32'(r_frame_done);
      r_line_cnt  <= (r_frame_done ? '0 : r_line_cnt) + WB'(w_rd && m_axis_tlast);
    end
  end
`endif
endmodule
